pipelined_dcache: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits directly downstream of the CPU datapath's D-Mem port.
- Serves MEM-stage requests with read data returned in the following (WB) cycle.
- Freezes the pipeline by deasserting dmem_resp while a miss is serviced over a 256-bit line-granular physical memory port.

---
 rtl/pipelined_dcache.sv | 159 +++++++++++++++
 tb/tb_pipelined_dcache.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_dcache.sv
// Direct-mapped write-back write-allocate L1 D-cache.
// Freezes the pipeline via dmem_resp while a line miss is serviced.
module pipelined_dcache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dmem_read,
  input  logic         dmem_write,
  input  logic [31:0]  dmem_address,
  input  logic [3:0]   dmem_byte_enable,
  input  logic [31:0]  dmem_wdata,
  input  logic         dmem_stall,
  output logic [31:0]  dmem_rdata,
  output logic         dmem_resp,
  output logic         dmem_ready,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int NS = 1 << S_INDEX;
  localparam int TW = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  state_t state, state_n;

  logic [NS-1:0]      valid;
  logic [NS-1:0]      dirty;
  logic [TW-1:0]      tag_arr  [NS];
  logic [255:0]       data_arr [NS];

  logic [S_INDEX-1:0] idx;
  logic [S_INDEX-1:0] miss_idx;
  logic [TW-1:0]      addr_tag;
  logic [TW-1:0]      miss_tag;
  logic [2:0]         wsel;
  logic [7:0]         wbit;

  logic req, hit, miss, rd_req, wr_req;
  logic [255:0] cur_line;
  logic [31:0]  cur_word;
  logic [31:0]  merged;
  logic [255:0] wr_line;
  logic         unused_addr;

  assign idx         = dmem_address[4+S_INDEX:5];
  assign addr_tag    = dmem_address[31:5+S_INDEX];
  assign wsel        = dmem_address[4:2];
  assign wbit        = {wsel, 5'b0};
  assign unused_addr = ^dmem_address[1:0];

  assign req    = (dmem_read | dmem_write) & ~dmem_stall;
  assign hit    = req & valid[idx] & (tag_arr[idx] == addr_tag);
  assign miss   = req & ~hit;
  assign wr_req = req & dmem_write;
  assign rd_req = req & dmem_read & ~dmem_write;

  assign cur_line = data_arr[idx];
  assign cur_word = cur_line[wbit +: 32];

  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (dmem_byte_enable[b]) merged[8*b +: 8] = dmem_wdata[8*b +: 8];
    end
    wr_line = cur_line;
    wr_line[wbit +: 32] = merged;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (miss && valid[idx] && dirty[idx]) state_n = WRITEBACK;
        else if (miss)                        state_n = FILL;
      end
      WRITEBACK: if (pmem_resp) state_n = FILL;
      FILL:      if (pmem_resp) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    dmem_resp    = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'b0;
    pmem_wdata   = 256'b0;
    unique case (state)
      IDLE: dmem_resp = ~miss;
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[miss_idx], miss_idx, 5'b0};
        pmem_wdata   = data_arr[miss_idx];
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag, miss_idx, 5'b0};
      end
      default: ;
    endcase
  end

  // Miss target is frozen on entry so later request changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && miss) begin
      miss_idx <= idx;
      miss_tag <= addr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == IDLE) begin
      if (wr_req && hit && |dmem_byte_enable) dirty[idx] <= 1'b1;
    end else if (state == FILL && pmem_resp) begin
      valid[miss_idx] <= 1'b1;
      dirty[miss_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && wr_req && hit) begin
        data_arr[idx] <= wr_line;
      end else if (state == FILL && pmem_resp) begin
        data_arr[miss_idx] <= pmem_rdata;
        tag_arr[miss_idx]  <= miss_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_rdata <= 32'b0;
      dmem_ready <= 1'b0;
    end else if (dmem_resp) begin
      dmem_ready <= rd_req;
      if (rd_req && hit) dmem_rdata <= cur_word;
    end
  end

endmodule

// File: tb/tb_pipelined_dcache.sv
// Directed bench for pipelined_dcache with a word-level
// reference memory, a read scoreboard and a pmem responder.
module tb_pipelined_dcache;

  logic         clk = 1'b0;
  logic         rst;
  logic         dmem_read, dmem_write, dmem_stall;
  logic [31:0]  dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]   dmem_byte_enable;
  logic         dmem_resp, dmem_ready;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;

  pipelined_dcache #(.S_INDEX(3)) dut (
    .clk(clk), .rst(rst),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_wdata(dmem_wdata), .dmem_stall(dmem_stall),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_ready(dmem_ready),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0]  exp_q [$];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [255:0] lmem [logic [31:0]];

  int rd_cyc, wr_cyc, overlap;
  logic prev_rd, prev_wr;
  logic [31:0]  rd_log [$];
  logic [31:0]  wr_log [$];
  logic [255:0] wd_log [$];

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[32*i +: 32] = {a[31:5], 5'(i*4)} ^ 32'hA5A5_0000;
    if (a == 32'h0000_1000) l[63:32] = 32'hDEADBEEF;
    return l;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] wa;
    logic [255:0] l;
    logic [7:0] sh;
    wa = {a[31:2], 2'b0};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    l = init_line({a[31:5], 5'b0});
    sh = {a[4:2], 5'b0};
    return l[sh +: 32];
  endfunction

  function automatic void model_wr(input logic [31:0] a,
                                   input logic [3:0] be,
                                   input logic [31:0] wd);
    logic [31:0] w;
    w = model_rd(a);
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    ref_mem[{a[31:2], 2'b0}] = w;
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[32*i +: 32] = model_rd(la + 32'(4*i));
    return l;
  endfunction

  task automatic clr_mon();
    rd_cyc = 0;
    wr_cyc = 0;
    overlap = 0;
    rd_log.delete();
    wr_log.delete();
    wd_log.delete();
  endtask

  task automatic set_idle();
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    dmem_stall = 1'b0;
    dmem_byte_enable = 4'h0;
    dmem_wdata = 32'h0;
  endtask

  // Present one request, wait out any freeze, then check the WB outputs.
  task automatic issue(input logic rd, input logic wr, input logic st,
                       input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input string tag,
                       output int lat);
    logic is_rd;
    dmem_read = rd;
    dmem_write = wr;
    dmem_stall = st;
    dmem_address = a;
    dmem_byte_enable = be;
    dmem_wdata = wd;
    is_rd = rd & ~wr & ~st;
    lat = 0;
    @(negedge clk);
    while (!dmem_resp && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, "_resp"}, 256'(dmem_resp), 256'(1));
    if (is_rd) exp_q.push_back(model_rd(a));
    if (wr && !st) model_wr(a, be, wd);
    @(posedge clk);
    #1;
    set_idle();
    if (is_rd) begin
      chk({tag, "_ready"}, 256'(dmem_ready), 256'(1));
      chk({tag, "_rdata"}, 256'(dmem_rdata), 256'(exp_q.pop_front()));
    end else begin
      chk({tag, "_ready"}, 256'(dmem_ready), 256'(0));
    end
  endtask

  initial begin : monitor
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (pmem_read) rd_cyc++;
      if (pmem_write) wr_cyc++;
      if (pmem_read && pmem_write) overlap = 1;
      if (pmem_read && !prev_rd) rd_log.push_back(pmem_address);
      if (pmem_write && !prev_wr) begin
        wr_log.push_back(pmem_address);
        wd_log.push_back(pmem_wdata);
      end
      prev_rd = pmem_read;
      prev_wr = pmem_write;
    end
  end

  initial begin : responder
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (!(pmem_read || pmem_write)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 3) begin
          pmem_resp = 1'b1;
          if (pmem_write) lmem[pmem_address] = pmem_wdata;
          else if (lmem.exists(pmem_address))
            pmem_rdata = lmem[pmem_address];
          else pmem_rdata = init_line(pmem_address);
        end
      end
    end
  end

  initial begin : stim
    int lat, n;
    set_idle();
    dmem_address = 32'h0;
    clr_mon();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", 256'(dmem_rdata), 256'(0));
    chk("rst_ready", 256'(dmem_ready), 256'(0));
    chk("rst_pread", 256'(pmem_read), 256'(0));
    chk("rst_pwrite", 256'(pmem_write), 256'(0));
    chk("rst_resp", 256'(dmem_resp), 256'(1));
    rst = 1'b0;

    clr_mon();
    issue(1, 0, 0, 32'h0000_1004, 4'h0, 32'h0, "cold", lat);
    chk("cold_word", 256'(dmem_rdata), 256'(32'hDEADBEEF));
    chk("cold_paddr", 256'(rd_log.size() > 0 ? rd_log[0] : 32'hX),
        256'(32'h0000_1000));
    chk("cold_lat", 256'(lat), 256'(rd_cyc + 1));
    chk("cold_nowb", 256'(wr_cyc), 256'(0));

    clr_mon();
    issue(1, 0, 0, 32'h0000_1000, 4'h0, 32'h0, "b2b0", lat);
    chk("b2b0_lat", 256'(lat), 256'(0));
    issue(1, 0, 0, 32'h0000_1008, 4'h0, 32'h0, "b2b1", lat);
    chk("b2b1_lat", 256'(lat), 256'(0));
    issue(1, 0, 0, 32'h0000_101C, 4'h0, 32'h0, "b2b2", lat);
    chk("b2b2_lat", 256'(lat), 256'(0));
    chk("b2b_pmem", 256'(rd_cyc + wr_cyc), 256'(0));

    issue(0, 1, 0, 32'h0000_1004, 4'h4, 32'h00AB_0000, "sb", lat);
    chk("sb_lat", 256'(lat), 256'(0));
    issue(1, 0, 0, 32'h0000_1004, 4'h0, 32'h0, "sbrd", lat);
    chk("sbrd_word", 256'(dmem_rdata), 256'(32'hDEABBEEF));

    issue(1, 0, 0, 32'h0000_1020, 4'h0, 32'h0, "s1fill", lat);
    issue(0, 1, 1, 32'h0000_1020, 4'hF, 32'h1234_5678, "stall", lat);
    chk("stall_lat", 256'(lat), 256'(0));
    issue(1, 0, 0, 32'h0000_1020, 4'h0, 32'h0, "stallrd", lat);
    clr_mon();
    issue(1, 0, 0, 32'h0000_2020, 4'h0, 32'h0, "s1evict", lat);
    chk("stall_clean", 256'(wr_cyc), 256'(0));

    clr_mon();
    issue(1, 0, 0, 32'h0000_2004, 4'h0, 32'h0, "evict", lat);
    chk("evict_waddr", 256'(wr_log.size() > 0 ? wr_log[0] : 32'hX),
        256'(32'h0000_1000));
    chk("evict_wdata", wd_log.size() > 0 ? wd_log[0] : 'x,
        model_line(32'h0000_1000));
    chk("evict_raddr", 256'(rd_log.size() > 0 ? rd_log[0] : 32'hX),
        256'(32'h0000_2000));
    chk("evict_overlap", 256'(overlap), 256'(0));
    chk("evict_lat", 256'(lat), 256'(wr_cyc + rd_cyc + 1));
    chk("evict_wcyc", 256'(wr_cyc > 0), 256'(1));

    clr_mon();
    issue(1, 0, 0, 32'h0000_1004, 4'h0, 32'h0, "reload", lat);
    chk("reload_word", 256'(dmem_rdata), 256'(32'hDEABBEEF));
    chk("reload_nowb", 256'(wr_cyc), 256'(0));

    dmem_read = 1'b1;
    dmem_address = 32'h0000_3004;
    n = 0;
    @(negedge clk);
    while (!pmem_read && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("rmf_fill", 256'(pmem_read), 256'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmf_pread", 256'(pmem_read), 256'(0));
    chk("rmf_ready", 256'(dmem_ready), 256'(0));
    rst = 1'b0;
    set_idle();
    clr_mon();
    issue(1, 0, 0, 32'h0000_3004, 4'h0, 32'h0, "rmf_re", lat);
    chk("rmf_remiss", 256'(rd_cyc > 0), 256'(1));
    chk("rmf_lat", 256'(lat), 256'(rd_cyc + 1));
    chk("rmf_paddr", 256'(rd_log.size() > 0 ? rd_log[0] : 32'hX),
        256'(32'h0000_3000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
